// File: rtl/op_scheduler_if.sv
// Handshake bundle between op_scheduler, its three requesters and the shared datapath.
// The scheduler takes the master view; requesters and datapath take the slave view.
interface op_scheduler_if;
    logic        dpp_ready_in;
    logic        nd_ready_in;
    logic        na_in;
    logic        op_done_in;
    logic [1:0]  opcode_out;
    logic        op_start_out;
    logic        dpp_ack_out;
    logic        nd_ack_out;
    logic        na_ack_out;
    logic        busy_out;
    logic        timeout_out;
    logic [15:0] op_count_out;

    modport master (
        input  dpp_ready_in, nd_ready_in, na_in, op_done_in,
        output opcode_out, op_start_out, dpp_ack_out, nd_ack_out, na_ack_out,
        output busy_out, timeout_out, op_count_out
    );

    modport slave (
        output dpp_ready_in, nd_ready_in, na_in, op_done_in,
        input  opcode_out, op_start_out, dpp_ack_out, nd_ack_out, na_ack_out,
        input  busy_out, timeout_out, op_count_out
    );
endinterface

// File: rtl/op_scheduler.sv
// Arbitrates TX / RX / LOG requests onto the shared packet datapath, holding each opcode
// until completion or timeout; RX wins by default, starved TX/LOG requesters get promoted.
module op_scheduler #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    op_scheduler_if.master  bus
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_TXE = 2'b01;
    localparam logic [1:0] OP_RXA = 2'b10;
    localparam logic [1:0] OP_LOG = 2'b11;

    localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT_CYCLES);

    state_t      state_r;
    logic [1:0]  opcode_r;
    logic        start_r;
    logic        dpp_ack_r;
    logic        nd_ack_r;
    logic        na_ack_r;
    logic        busy_r;
    logic        timeout_r;
    logic [15:0] count_r;
    logic [3:0]  tx_starve_r;
    logic [3:0]  log_starve_r;
    logic [7:0]  tmo_cnt_r;

    logic        tx_promote_s;
    logic        log_promote_s;
    logic [1:0]  grant_op_s;

    // A requester that drops its line between grants loses its accumulated starvation credit.
    function automatic logic [3:0] starve_next(input logic granted, input logic requesting,
                                               input logic [3:0] cnt);
        logic [3:0] nxt;
        if (granted) begin
            nxt = 4'd0;
        end else if (!requesting) begin
            nxt = 4'd0;
        end else if (cnt >= STARVE_MAX) begin
            nxt = STARVE_MAX;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

    assign tx_promote_s  = bus.dpp_ready_in && (tx_starve_r == STARVE_MAX);
    assign log_promote_s = bus.na_in && (log_starve_r == STARVE_MAX);

    // Priority pick: promoted TX, promoted LOG, then RX > TX > LOG; NOP means nothing to grant.
    always_comb begin
        grant_op_s = OP_NOP;
        if (tx_promote_s) begin
            grant_op_s = OP_TXE;
        end else if (log_promote_s) begin
            grant_op_s = OP_LOG;
        end else if (bus.nd_ready_in) begin
            grant_op_s = OP_RXA;
        end else if (bus.dpp_ready_in) begin
            grant_op_s = OP_TXE;
        end else if (bus.na_in) begin
            grant_op_s = OP_LOG;
        end else begin
            grant_op_s = OP_NOP;
        end
    end

    // Scheduler FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            opcode_r     <= OP_NOP;
            start_r      <= 1'b0;
            dpp_ack_r    <= 1'b0;
            nd_ack_r     <= 1'b0;
            na_ack_r     <= 1'b0;
            busy_r       <= 1'b0;
            timeout_r    <= 1'b0;
            count_r      <= 16'd0;
            tx_starve_r  <= 4'd0;
            log_starve_r <= 4'd0;
            tmo_cnt_r    <= 8'd0;
        end else begin
            start_r   <= 1'b0;
            dpp_ack_r <= 1'b0;
            nd_ack_r  <= 1'b0;
            na_ack_r  <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_op_s != OP_NOP) begin
                        state_r      <= ST_BUSY;
                        opcode_r     <= grant_op_s;
                        start_r      <= 1'b1;
                        dpp_ack_r    <= (grant_op_s == OP_TXE);
                        nd_ack_r     <= (grant_op_s == OP_RXA);
                        na_ack_r     <= (grant_op_s == OP_LOG);
                        busy_r       <= 1'b1;
                        tmo_cnt_r    <= 8'd0;
                        tx_starve_r  <= starve_next(grant_op_s == OP_TXE, bus.dpp_ready_in,
                                                    tx_starve_r);
                        log_starve_r <= starve_next(grant_op_s == OP_LOG, bus.na_in,
                                                    log_starve_r);
                    end else begin
                        opcode_r <= OP_NOP;
                        busy_r   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Completion on the final allowed cycle beats the timeout.
                    if (bus.op_done_in) begin
                        state_r  <= ST_IDLE;
                        opcode_r <= OP_NOP;
                        busy_r   <= 1'b0;
                        count_r  <= count_r + 16'd1;
                    end else if (tmo_cnt_r == TIMEOUT_MAX) begin
                        state_r   <= ST_IDLE;
                        opcode_r  <= OP_NOP;
                        busy_r    <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    opcode_r <= OP_NOP;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.opcode_out   = opcode_r;
    assign bus.op_start_out = start_r;
    assign bus.dpp_ack_out  = dpp_ack_r;
    assign bus.nd_ack_out   = nd_ack_r;
    assign bus.na_ack_out   = na_ack_r;
    assign bus.busy_out     = busy_r;
    assign bus.timeout_out  = timeout_r;
    assign bus.op_count_out = count_r;
endmodule

// File: tb/tb_op_scheduler.sv
// Self-checking bench for op_scheduler: directed vector table, hand-written timeout /
// back-to-back / reset / wrap sequences, then random traffic against a reference model.
module tb_op_scheduler;
    localparam int STARVE_LIMIT   = 4;
    localparam int TIMEOUT_CYCLES = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    op_scheduler_if bus();

    op_scheduler #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        dpp, nd, na, done;
        logic [1:0]  op;
        logic        start;
        logic [2:0]  ack;   // {dpp, nd, na}
        logic        busy, tmo;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[20];

    // Reference model state
    bit          m_busy;
    int          m_len;
    int          m_tx, m_log;
    logic [15:0] m_cnt;
    logic [1:0]  m_op;
    logic        m_start, m_tmo;
    logic [2:0]  m_ack;

    function automatic vec_t mkv(input logic [3:0] inp, input logic [1:0] op, input logic start,
                                 input logic [2:0] ack, input logic busy, input logic tmo,
                                 input logic [15:0] cnt);
        vec_t v;
        v.dpp = inp[3]; v.nd = inp[2]; v.na = inp[1]; v.done = inp[0];
        v.op = op; v.start = start; v.ack = ack; v.busy = busy; v.tmo = tmo; v.cnt = cnt;
        return v;
    endfunction

    function automatic logic [23:0] out_vec();
        return {bus.opcode_out, bus.op_start_out, bus.dpp_ack_out, bus.nd_ack_out,
                bus.na_ack_out, bus.busy_out, bus.timeout_out, bus.op_count_out};
    endfunction

    function automatic logic [23:0] pack(input logic [1:0] op, input logic start,
                                         input logic [2:0] ack, input logic busy,
                                         input logic tmo, input logic [15:0] cnt);
        return {op, start, ack, busy, tmo, cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic n, input logic a, input logic done);
        bus.dpp_ready_in = d;
        bus.nd_ready_in  = n;
        bus.na_in        = a;
        bus.op_done_in   = done;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_len = 0; m_tx = 0; m_log = 0; m_cnt = 16'd0;
        m_op = 2'b00; m_start = 1'b0; m_tmo = 1'b0; m_ack = 3'b000;
    endtask

    // One clock edge of the scheduler, described by its rules rather than its registers.
    task automatic model_edge(input bit rn, input bit d, input bit n, input bit a, input bit done);
        int cand[$];
        int winner;
        bit want;
        m_start = 1'b0; m_tmo = 1'b0; m_ack = 3'b000;
        if (!rn) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (m_tx == STARVE_LIMIT) cand.push_back(1);
            if (m_log == STARVE_LIMIT) cand.push_back(3);
            cand.push_back(2); cand.push_back(1); cand.push_back(3);
            winner = 0;
            foreach (cand[i]) begin
                want = (cand[i] == 1) ? d : (cand[i] == 2) ? n : a;
                if (winner == 0 && want) winner = cand[i];
            end
            if (winner != 0) begin
                m_tx  = (winner == 1 || !d) ? 0 : ((m_tx + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_tx + 1);
                m_log = (winner == 3 || !a) ? 0 : ((m_log + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_log + 1);
                m_busy  = 1'b1;
                m_len   = 0;
                m_op    = 2'(winner);
                m_start = 1'b1;
                m_ack   = (winner == 1) ? 3'b100 : (winner == 2) ? 3'b010 : 3'b001;
            end else begin
                m_op = 2'b00;
            end
        end else begin
            m_len++;
            if (done) begin
                m_busy = 1'b0; m_op = 2'b00; m_cnt = m_cnt + 16'd1;
            end else if (m_len > TIMEOUT_CYCLES) begin
                m_busy = 1'b0; m_op = 2'b00; m_tmo = 1'b1;
            end
        end
    endtask

    // LOG operation finishing with done on busy cycle done_at (0 = never, times out).
    task automatic tmo_case(input int done_at, inout logic [15:0] cnt);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("tmo_grant", out_vec(), pack(2'b11, 1'b1, 3'b001, 1'b1, 1'b0, cnt));
        bus.na_in = 1'b0;
        for (int i = 1; i <= TIMEOUT_CYCLES + 1; i++) begin
            bus.op_done_in = (i == done_at);
            tick();
            if (i == done_at) begin
                cnt = cnt + 16'd1;
                check("tmo_done", out_vec(), pack(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, cnt));
                break;
            end else if (i == TIMEOUT_CYCLES + 1) begin
                check("tmo_fire", out_vec(), pack(2'b00, 1'b0, 3'b000, 1'b0, 1'b1, cnt));
            end else begin
                check("tmo_hold", out_vec(), pack(2'b11, 1'b0, 3'b000, 1'b1, 1'b0, cnt));
            end
        end
        bus.op_done_in = 1'b0;
        tick();
        check("tmo_after", out_vec(), pack(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cnt;
        bit rq_d, rq_n, rq_a, dn, rn;
        int done_pct;

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick(); tick();
        check("reset_state", out_vec(), 32'd0);
        reset_n = 1'b1;

        // inputs {dpp,nd,na,done} | opcode, start, ack{dpp,nd,na}, busy, timeout, count
        tbl[0]  = mkv(4'b0000, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd0);
        tbl[1]  = mkv(4'b1000, 2'b01, 1'b1, 3'b100, 1'b1, 1'b0, 16'd0);
        tbl[2]  = mkv(4'b0000, 2'b01, 1'b0, 3'b000, 1'b1, 1'b0, 16'd0);
        tbl[3]  = mkv(4'b0000, 2'b01, 1'b0, 3'b000, 1'b1, 1'b0, 16'd0);
        tbl[4]  = mkv(4'b0001, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd1);
        tbl[5]  = mkv(4'b1110, 2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 16'd1);
        tbl[6]  = mkv(4'b1111, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd2);
        tbl[7]  = mkv(4'b1110, 2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 16'd2);
        tbl[8]  = mkv(4'b1111, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd3);
        tbl[9]  = mkv(4'b1110, 2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 16'd3);
        tbl[10] = mkv(4'b1111, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd4);
        tbl[11] = mkv(4'b1110, 2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 16'd4);
        tbl[12] = mkv(4'b1111, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd5);
        tbl[13] = mkv(4'b1110, 2'b01, 1'b1, 3'b100, 1'b1, 1'b0, 16'd5);
        tbl[14] = mkv(4'b1111, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd6);
        tbl[15] = mkv(4'b1110, 2'b11, 1'b1, 3'b001, 1'b1, 1'b0, 16'd6);
        tbl[16] = mkv(4'b1111, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd7);
        tbl[17] = mkv(4'b1110, 2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 16'd7);
        tbl[18] = mkv(4'b0001, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd8);
        tbl[19] = mkv(4'b0001, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'd8);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].dpp, tbl[i].nd, tbl[i].na, tbl[i].done);
            tick();
            check($sformatf("vec%0d", i), out_vec(),
                  pack(tbl[i].op, tbl[i].start, tbl[i].ack, tbl[i].busy, tbl[i].tmo, tbl[i].cnt));
        end

        cnt = 16'd8;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tmo_case(0, cnt);
        tmo_case(TIMEOUT_CYCLES, cnt);
        tmo_case(TIMEOUT_CYCLES + 1, cnt);

        // Back-to-back RX with done on the start cycle: 10,00,10,00...
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("b2b%0d", i), {29'd0, bus.opcode_out, bus.op_start_out},
                  (i % 2 == 0) ? 32'd5 : 32'd0);
        end

        // Reset while an RX operation is outstanding
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        check("pre_reset_busy", {30'd0, bus.opcode_out}, 32'd2);
        reset_n = 1'b0;
        tick();
        check("reset_mid_busy", out_vec(), 32'd0);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_after_reset", out_vec(), 32'd0);
        end

        // Counter wrap from 0xFFFF
        @(negedge clk);
        force dut.count_r = 16'hFFFF;
        #1;
        release dut.count_r;
        #1;
        check("wrap_preload", {16'd0, bus.op_count_out}, 32'h0000FFFF);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("wrap", out_vec(), pack(2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000));
        tick();
        check("idle_done_ignored", out_vec(), 32'd0);

        // Random traffic against the reference model
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_reset();
        rq_d = 1'b0; rq_n = 1'b0; rq_a = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            done_pct = (c < 2000) ? 30 : 10;
            if (rq_d) rq_d = m_ack[2] ? ($urandom_range(99) < 50) : ($urandom_range(99) >= 5);
            else      rq_d = ($urandom_range(99) < 30);
            if (rq_n) rq_n = m_ack[1] ? ($urandom_range(99) < 50) : ($urandom_range(99) >= 5);
            else      rq_n = ($urandom_range(99) < 30);
            if (rq_a) rq_a = m_ack[0] ? ($urandom_range(99) < 50) : ($urandom_range(99) >= 5);
            else      rq_a = ($urandom_range(99) < 30);
            dn = ($urandom_range(99) < done_pct);
            rn = ($urandom_range(199) != 0);
            drive(rq_d, rq_n, rq_a, dn);
            reset_n = rn;
            model_edge(rn, rq_d, rq_n, rq_a, dn);
            tick();
            check("rand", out_vec(), pack(m_op, m_start, m_ack, m_busy, m_tmo, m_cnt));
        end
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/op_scheduler.md
# op_scheduler

Sequences the shared packet-processing datapath. It arbitrates between three requesters: host transmit (DPP), network receive (ND) and logging (NA). Receive has the highest default priority, with anti-starvation promotion for the others. Each granted operation is issued as an opcode plus start pulse, and the opcode is held until the datapath reports completion or a timeout aborts it.

## Interface
- STARVE_LIMIT, 4: consecutive lost arbitrations after which a waiting TX or LOG requester is promoted (1..15)
- TIMEOUT_CYCLES, 255: maximum BUSY cycles allowed for an operation without op_done_in (1..255)
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- dpp_ready_in  in  1  host packet ready; TX request, level, held until acked
- nd_ready_in  in  1  network data ready; RX request, level, held until acked
- na_in  in  1  log request, level, held until acked
- op_done_in  in  1  datapath completion strobe; honoured only in BUSY
- opcode_out  out  2  00 NOP, 01 TXE, 10 RXA, 11 LOG
- op_start_out  out  1  one-cycle pulse on the first cycle a new opcode is presented
- dpp_ack_out / nd_ack_out / na_ack_out  out  1 each  one-cycle grant pulse, coincident with op_start_out
- busy_out  out  1  high while an operation is outstanding
- timeout_out  out  1  one-cycle pulse when an operation is aborted
- op_count_out  out  16  count of completed (non-aborted) operations, wraps 0xFFFF→0

## Operation
- Reset (reset_n=0 at an edge) forces the following. Any in-flight operation is abandoned, with no timeout pulse.
  - state IDLE
  - opcode_out=NOP
  - op_start_out, all acks, busy_out, timeout_out = 0
  - op_count_out = 0
  - starvation and timeout counters = 0
- FSM states:
  - IDLE: if any request is high, grant per arbitration and go to BUSY; otherwise stay, with opcode NOP.
  - BUSY: hold the opcode. On op_done_in=1, go to IDLE and increment op_count_out. Otherwise increment the timeout counter. If the counter already equals TIMEOUT_CYCLES, pulse timeout_out and go to IDLE without counting the operation.
- Arbitration is evaluated only in IDLE, highest first:
  - TX if tx_starve==STARVE_LIMIT
  - LOG if log_starve==STARVE_LIMIT
  - RX
  - TX
  - LOG
- Starvation counters are updated at every grant, for TX and LOG independently:
  - granted → 0
  - requesting but not granted → +1, saturating at STARVE_LIMIT
  - not requesting → 0
- RX has no starvation counter.
- The timeout counter is cleared at grant. It counts BUSY cycles; the first BUSY cycle counts as 1.
- op_done_in in IDLE is ignored and produces no count.

## Timing
- Grant latency: a request is sampled in IDLE at edge N. From N+1, state is BUSY, opcode_out is valid, busy_out=1, and op_start_out plus the matching ack are high for exactly that cycle.
- op_done_in may arrive in the start cycle itself, which is the minimum operation length of 1 BUSY cycle.
- Completion: op_done_in=1 is sampled in BUSY at edge M. From M+1, opcode_out=NOP, busy_out=0 and op_count_out is incremented.
- The next grant is sampled at edge M+1 and presented at M+2. This guarantees at least one NOP cycle between operations.
- Timeout: done absent for TIMEOUT_CYCLES BUSY cycles → at the following edge, timeout_out=1 for one cycle, opcode NOP, busy 0. If done arrives on that same final cycle, done wins: completion, no timeout.
- Requests asserted during BUSY are not acked until the next IDLE evaluation. A request dropped before being acked is forgotten.
- Simultaneous requests: exactly one ack per grant. Unserved requesters must keep their request high.
- op_count_out increments by exactly 1 per completion and wraps silently.

## Test plan
- Reset: hold reset_n=0 mid-BUSY with RX opcode 10 → next cycle all outputs 0, opcode 00, op_count_out 0. After release, with no requests, outputs stay idle.
- Single TX: dpp_ready_in=1 at edge 0 → at cycle 1, opcode 01, op_start_out and dpp_ack_out pulse. Then op_done_in at cycle 3 → cycle 4 opcode 00, busy 0, op_count_out=1.
- Priority: all three requests held, each op done after 1 cycle, STARVE_LIMIT=4. Required grant order: RX, RX, RX, RX, TX (promoted), LOG (promoted). LOG's counter had also saturated, so it is served right after TX.
- Timeout: TIMEOUT_CYCLES=5, LOG granted, op_done_in never asserted → timeout_out pulses exactly 6 cycles after op_start_out, op_count_out unchanged. Variant: done on the 5th BUSY cycle → no timeout, count +1.
- Back-to-back: nd_ready_in held high, done on the start cycle each time → opcode pattern 10, 00, 10, 00…, one start per two cycles.
- Wrap: preload 0xFFFF completions (or force the counter) then complete one operation → op_count_out = 0x0000. A done strobe while IDLE → no count change.
